// File: rtl/ascon_rand_gen.sv
// ascon_rand_gen: fresh-randomness source for the masked Ascon permutation.
// A bank of NUM_LFSR seeded Fibonacci LFSRs is loaded serially, warmed up for
// WARMUP_CYCLES advances, and then delivers DATA_WIDTH bits per valid/ready
// handshake. Each advance unrolls STEPS LFSR steps, so no bit is ever reused.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   seed_i           seed word for the LFSR currently being loaded
//   seed_valid_i     seed word valid
//   seed_ready_o     block accepts a seed word (SEED state)
//   reseed_i         discard current state and reload seeds (WARM/RUN only)
//   rnd_o            random bits, {lfsr[NUM_LFSR-1]..lfsr[0]} truncated
//   rnd_valid_o      rnd_o is fresh (RUN state)
//   rnd_ready_i      consumer takes rnd_o
//   busy_o           high while seeding or warming up
module ascon_rand_gen #(
  parameter int unsigned DATA_WIDTH    = 286,
  parameter int unsigned LFSR_WIDTH    = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY = 31'h10000001,
  parameter int unsigned NUM_LFSR      = (DATA_WIDTH + LFSR_WIDTH - 1) / LFSR_WIDTH,
  parameter int unsigned STEPS         = 31,
  parameter int unsigned WARMUP_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LFSR_WIDTH-1:0] seed_i,
  input  logic                  seed_valid_i,
  output logic                  seed_ready_o,
  input  logic                  reseed_i,
  output logic [DATA_WIDTH-1:0] rnd_o,
  output logic                  rnd_valid_o,
  input  logic                  rnd_ready_i,
  output logic                  busy_o
);

  localparam int unsigned SCNT_W = (NUM_LFSR > 1) ? $clog2(NUM_LFSR) : 1;
  localparam int unsigned WCNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_SEED = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [SCNT_W-1:0]       scnt_q, scnt_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic [LFSR_WIDTH-1:0]   lfsr_q [NUM_LFSR];
  logic [LFSR_WIDTH-1:0]   lfsr_d [NUM_LFSR];
  logic                    advance;

  // STEPS Fibonacci steps unrolled into one combinational advance.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_adv(input logic [LFSR_WIDTH-1:0] s);
    logic [LFSR_WIDTH-1:0] v;
    v = s;
    for (int unsigned k = 0; k < STEPS; k++) begin
      v = {v[LFSR_WIDTH-2:0], ^(v & LFSR_POLY)};
    end
    return v;
  endfunction

  // State and LFSR bank registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_SEED;
      scnt_q  <= '0;
      wcnt_q  <= '0;
      for (int unsigned i = 0; i < NUM_LFSR; i++) begin
        lfsr_q[i] <= LFSR_WIDTH'(1);
      end
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      wcnt_q  <= wcnt_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Next-state, counter and LFSR-bank update.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    wcnt_d  = wcnt_q;
    lfsr_d  = lfsr_q;
    advance = 1'b0;

    case (state_q)
      ST_SEED: begin
        if (seed_valid_i) begin
          for (int unsigned i = 0; i < NUM_LFSR; i++) begin
            if (scnt_q == SCNT_W'(i)) begin
              // An all-zero state would lock the LFSR forever.
              lfsr_d[i] = (seed_i == '0) ? LFSR_WIDTH'(1) : seed_i;
            end
          end
          if (scnt_q == SCNT_W'(NUM_LFSR - 1)) begin
            state_d = ST_WARM;
            scnt_d  = '0;
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
      end
      ST_WARM: begin
        if (reseed_i) begin
          state_d = ST_SEED;
          scnt_d  = '0;
          wcnt_d  = '0;
        end else begin
          advance = 1'b1;
          if (wcnt_q == WCNT_W'(WARMUP_CYCLES - 1)) begin
            state_d = ST_RUN;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
      ST_RUN: begin
        // A handshake coinciding with reseed still consumes the word.
        advance = rnd_ready_i;
        if (reseed_i) begin
          state_d = ST_SEED;
          scnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_SEED;
        scnt_d  = '0;
        wcnt_d  = '0;
      end
    endcase

    if (advance) begin
      for (int unsigned i = 0; i < NUM_LFSR; i++) begin
        lfsr_d[i] = lfsr_adv(lfsr_q[i]);
      end
    end
  end

  // Handshake flags are pure state decodes.
  assign seed_ready_o = (state_q == ST_SEED);
  assign rnd_valid_o  = (state_q == ST_RUN);
  assign busy_o       = (state_q != ST_RUN);

  // Output word: LFSR bank flattened LSB-first, truncated to DATA_WIDTH.
  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_rnd
    assign rnd_o[b] = lfsr_q[b / LFSR_WIDTH][b % LFSR_WIDTH];
  end

endmodule

// File: tb/tb_ascon_rand_gen.sv
// Scoreboard bench for ascon_rand_gen: a word-level model predicts every
// delivered word; a negedge monitor pops and compares on each handshake.
module tb_ascon_rand_gen;

  localparam int DW = 286;
  localparam int LW = 31;
  localparam int NL = 10;
  localparam int WARM = 64;
  localparam logic [LW-1:0] POLY = 31'h10000001;

  typedef logic [LW-1:0] seeds_t [NL];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [LW-1:0] seed_i = '0;
  logic          seed_valid_i = 1'b0;
  logic          seed_ready_o;
  logic          reseed_i = 1'b0;
  logic [DW-1:0] rnd_o;
  logic          rnd_valid_o;
  logic          rnd_ready_i = 1'b0;
  logic          busy_o;

  int checks = 0;
  int failures = 0;

  logic [LW-1:0] m [NL];
  logic [DW-1:0] exp_q [$];

  ascon_rand_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seed_i       (seed_i),
    .seed_valid_i (seed_valid_i),
    .seed_ready_o (seed_ready_o),
    .reseed_i     (reseed_i),
    .rnd_o        (rnd_o),
    .rnd_valid_o  (rnd_valid_o),
    .rnd_ready_i  (rnd_ready_i),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  // Model: shift left, feed back parity of tapped bits; 31 steps per advance.
  function automatic logic [LW-1:0] model_adv(input logic [LW-1:0] s);
    longint unsigned v;
    v = longint'(s);
    for (int k = 0; k < 31; k++) begin
      v = ((v << 1) | longint'($countones(v & longint'(POLY)) % 2)) & 64'h7FFF_FFFF;
    end
    return LW'(v);
  endfunction

  function automatic logic [DW-1:0] model_word();
    logic [NL*LW-1:0] cat;
    for (int i = 0; i < NL; i++) cat[i*LW +: LW] = m[i];
    return cat[DW-1:0];
  endfunction

  task automatic model_advance();
    for (int i = 0; i < NL; i++) m[i] = model_adv(m[i]);
  endtask

  task automatic model_seed(input seeds_t s);
    for (int i = 0; i < NL; i++) m[i] = (s[i] == '0) ? LW'(1) : s[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    seed_valid_i = 1'b0;
    reseed_i = 1'b0;
    rnd_ready_i = 1'b0;
    tick();
    tick();
    for (int i = 0; i < NL; i++) m[i] = LW'(1);
    check("rst_seed_ready", DW'(seed_ready_o), DW'(1));
    check("rst_rnd_valid", DW'(rnd_valid_o), DW'(0));
    check("rst_busy", DW'(busy_o), DW'(1));
    check("rst_rnd", rnd_o, model_word());
    rst_n = 1'b1;
  endtask

  task automatic load_seeds(input seeds_t s, input int n);
    for (int i = 0; i < n; i++) begin
      seed_i = s[i];
      seed_valid_i = 1'b1;
      check("seed_ready", DW'(seed_ready_o), DW'(1));
      tick();
    end
    seed_valid_i = 1'b0;
  endtask

  // Count cycles from the last seed beat to rnd_valid_o; then apply warm-up to the model.
  task automatic wait_warm();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!rnd_valid_o && k < 200);
    check("warm_latency", DW'(k), DW'(WARM));
    check("run_busy", DW'(busy_o), DW'(0));
    check("run_seed_ready", DW'(seed_ready_o), DW'(0));
    for (int i = 0; i < WARM; i++) model_advance();
  endtask

  task automatic run_words(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_word());
      model_advance();
    end
    rnd_ready_i = 1'b1;
    repeat (n) tick();
    rnd_ready_i = 1'b0;
  endtask

  function automatic seeds_t rand_seeds();
    seeds_t s;
    for (int i = 0; i < NL; i++) s[i] = LW'($urandom());
    return s;
  endfunction

  // Monitor: every handshake pops one expected word; consecutive words must differ.
  logic [DW-1:0] last_w;
  bit            have_last = 1'b0;
  always @(negedge clk) begin
    if (rst_n && rnd_valid_o && rnd_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%0h expected=none", rnd_o);
      end else begin
        check("word", rnd_o, exp_q.pop_front());
      end
      if (have_last) begin
        checks++;
        if (rnd_o == last_w) begin
          failures++;
          $display("FAIL distinct actual=%0h expected=different from previous", rnd_o);
        end
      end
      last_w = rnd_o;
      have_last = 1'b1;
    end else begin
      have_last = 1'b0;
    end
  end

  initial begin
    seeds_t s;
    logic [DW-1:0] held;
    bit hold_ok;
    bit early_valid;

    // All-zero seeds load 31'h1 everywhere.
    do_reset();
    for (int i = 0; i < NL; i++) s[i] = '0;
    load_seeds(s, NL);
    model_seed(s);
    wait_warm();
    run_words(3);

    // Seeds 1..10, 100 back-to-back words.
    do_reset();
    for (int i = 0; i < NL; i++) s[i] = LW'(i + 1);
    load_seeds(s, NL);
    model_seed(s);
    wait_warm();
    run_words(100);

    // Backpressure: word and valid hold, then successors follow.
    held = rnd_o;
    check("hold_start", held, model_word());
    hold_ok = 1'b1;
    repeat (20) begin
      tick();
      if (rnd_o !== held || rnd_valid_o !== 1'b1) hold_ok = 1'b0;
    end
    check("hold_stable", DW'(hold_ok), DW'(1));
    run_words(2);

    // Reseed coinciding with a handshake: word consumed, back to SEED.
    exp_q.push_back(model_word());
    model_advance();
    rnd_ready_i = 1'b1;
    reseed_i = 1'b1;
    tick();
    rnd_ready_i = 1'b0;
    reseed_i = 1'b0;
    check("reseed_valid", DW'(rnd_valid_o), DW'(0));
    check("reseed_seed_ready", DW'(seed_ready_o), DW'(1));
    check("reseed_busy", DW'(busy_o), DW'(1));
    s = rand_seeds();
    s[3] = '0;
    load_seeds(s, NL);
    model_seed(s);
    wait_warm();
    run_words(5);

    // Reset after a partial seed load; only the new seeds matter.
    do_reset();
    s = rand_seeds();
    load_seeds(s, 5);
    do_reset();
    s = rand_seeds();
    load_seeds(s, NL);
    model_seed(s);
    wait_warm();
    run_words(5);

    // Reseed during WARM at warm count 30.
    reseed_i = 1'b1;
    tick();
    reseed_i = 1'b0;
    check("run_reseed_seed_ready", DW'(seed_ready_o), DW'(1));
    s = rand_seeds();
    load_seeds(s, NL);
    early_valid = 1'b0;
    repeat (30) begin
      tick();
      if (rnd_valid_o) early_valid = 1'b1;
    end
    reseed_i = 1'b1;
    tick();
    reseed_i = 1'b0;
    check("warm_no_valid", DW'(early_valid), DW'(0));
    check("warm_reseed_valid", DW'(rnd_valid_o), DW'(0));
    check("warm_reseed_seed_ready", DW'(seed_ready_o), DW'(1));
    s = rand_seeds();
    load_seeds(s, NL);
    model_seed(s);
    wait_warm();
    run_words(5);

    tick();
    check("queue_empty", DW'(exp_q.size()), DW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
